loproc_divider: RTL and testbench
=================================

LOPROC_DIVIDER -- requirements
Module: loproc_divider

Interface
REQ-001 SHALL use parameter DATA_WIDTH, default 32 (`DATA_WIDTH from loproc_defines.vh), as the operand width.
REQ-002 SHALL use parameter DATA_LOG2, default 5, as the iteration counter width.
REQ-003 SHALL have port div_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port div_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in1, input, DATA_WIDTH, the unsigned dividend.
REQ-006 SHALL have port in2, input, DATA_WIDTH, the unsigned divisor.
REQ-007 SHALL have port valid_in, input, 1, operand strobe.
REQ-008 SHALL have port out_q, output, DATA_WIDTH, the quotient.
REQ-009 SHALL have port out_r, output, DATA_WIDTH, the remainder.
REQ-010 SHALL have port valid_out, output, 1, the one-cycle result pulse.
REQ-011 SHALL have port busy, output, 1, high while iterating.
REQ-012 SHALL have port div_by_zero, output, 1, flag qualified by valid_out.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY, DONE; busy=1 only in BUSY.
REQ-014 SHALL accept valid_in only when busy=0 (IDLE or DONE): latch in1/in2, clear remainder accumulator, load quotient/shift register with in1, load iteration counter, go to BUSY.
REQ-015 SHALL ignore valid_in while busy=1; registers and outputs are not disturbed.
REQ-016 SHALL perform one radix-2 restoring step per BUSY cycle:
- shift {rem, q} left by 1
- if (rem_shifted >= divisor), subtract the divisor and set the q LSB to 1; else set it to 0.
REQ-017 SHALL use a DATA_WIDTH+1-bit compare/subtract so there is no overflow for divisors >= 2^31.
REQ-018 SHALL, without DIV_EARLY_TERM_EN, execute exactly 32 BUSY cycles; then DONE for one cycle; valid_out=1 in the cycle after the 32nd iteration edge (33 edges after the capture edge).
REQ-019 SHALL, in DONE, drive valid_out=1 for exactly one cycle, then return to IDLE unless valid_in is high that cycle, in which case it goes to BUSY with the new operands.
REQ-020 SHALL hold out_q/out_r stable from DONE until the next accepted valid_in; they are undefined while busy=1.
REQ-021 SHALL treat in2==0 as divide by zero: skip BUSY, go directly to DONE on the next edge, and produce out_q=all ones, out_r=in1, div_by_zero=1.
REQ-022 SHALL clear div_by_zero on the next accepted valid_in.
REQ-023 SHALL follow the normal path when in1==0 with a nonzero divisor, producing q=0 and r=0.

Reset
REQ-024 SHALL, on div_rst high at an edge, force state IDLE and clear out_q, out_r, valid_out, busy, div_by_zero, counter, and operand registers to 0.
REQ-025 SHALL make div_rst take priority over valid_in and abort any in-flight divide with no valid_out pulse.
REQ-026 SHALL accept valid_in on the first edge after div_rst deasserts.

Configuration
REQ-027 SHALL gate early termination with macro DIV_EARLY_TERM_EN.
- When defined: at capture, a priority encoder computes lz = leading-zero count of in1; the dividend is pre-shifted left by lz; the counter starts at lz; BUSY lasts 32-lz cycles.
- When in1==0 (lz=32), BUSY is skipped and DONE follows the capture edge.
- Results are identical to the non-early-termination path.
- When undefined: fixed 32-cycle BUSY and no encoder logic.

Verification
REQ-028 SHALL cover: in1=100, in2=7 -> out_q=14, out_r=2, div_by_zero=0, valid_out one cycle, 33 edges after capture (macro off).
REQ-029 SHALL cover: in1=0xFFFFFFFF, in2=1 -> out_q=0xFFFFFFFF, out_r=0; and in1=0xFFFFFFFF, in2=0x80000000 -> out_q=1, out_r=0x7FFFFFFF.
REQ-030 SHALL cover: in1=5, in2=0 -> valid_out 1 edge after DONE entry (2 edges after capture), out_q=0xFFFFFFFF, out_r=5, div_by_zero=1; the next op (9/3) clears the flag, giving q=3, r=0.
REQ-031 SHALL cover: start 100/7, pulse valid_in with 50/5 at iteration 10 -> ignored; result is 14/2; 50/5 issued in the DONE cycle -> accepted, giving 10/0.
REQ-032 SHALL cover: div_rst asserted at iteration 16 -> all outputs 0, no valid_out; 20/6 issued after reset -> q=3, r=2.
REQ-033 SHALL cover, with DIV_EARLY_TERM_EN defined: 3/2 -> q=1, r=1, with valid_out 3 edges after capture; 0/9 -> q=0, r=0, with valid_out 2 edges after capture; and 1000 random pairs match the reference model with the macro both on and off.

Source files
------------

// File: rtl/loproc_divider.sv
// -----------------------------------------------------------------------------
// loproc_divider
// Iterative unsigned divider: one radix-2 restoring step per clock.
//
// Ports
//   div_clk      in   clock, all logic on the rising edge
//   div_rst      in   synchronous active-high reset, priority over everything
//   in1          in   DATA_WIDTH  dividend
//   in2          in   DATA_WIDTH  divisor
//   valid_in     in   operand strobe, accepted only while busy is low
//   out_q        out  DATA_WIDTH  quotient (held from DONE until next accept)
//   out_r        out  DATA_WIDTH  remainder (held from DONE until next accept)
//   valid_out    out  one-cycle result pulse, high during DONE
//   busy         out  high while iterating
//   div_by_zero  out  divide-by-zero flag, qualified by valid_out
//
// Timing (capture edge = edge that accepts valid_in)
//   normal divide : valid_out visible after capture edge + 32
//   zero-iteration: valid_out visible after capture edge + 1
//                   (divisor == 0, or dividend == 0 with early termination)
//
// Build option
//   DIV_EARLY_TERM_EN : when defined, the dividend is normalised at capture by
//   its leading-zero count and only the significant bits are iterated.
//   Undefined (default): fixed 32 iterations, no leading-zero encoder.
//
// DATA_WIDTH defaults to 32.
// -----------------------------------------------------------------------------
module loproc_divider #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_LOG2  = 5
) (
    input  logic                  div_clk,
    input  logic                  div_rst,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  div_by_zero
);

    localparam int unsigned            CW   = DATA_LOG2 + 1;
    localparam logic [DATA_LOG2-1:0]   LAST = DATA_LOG2'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_LOG2-1:0]  cnt;
    // A zero-iteration operation was captured and resolves on the next edge.
    logic                  skip;

    logic                  zero_iter_c;
    logic [DATA_WIDTH-1:0] quo_load_c;
    logic [DATA_LOG2-1:0]  cnt_load_c;

    logic                  accept_c;
    logic                  step_c;
    logic                  finish_c;
    logic                  resolve_c;

    logic [DATA_WIDTH:0]   rem_sh_c;
    logic [DATA_WIDTH:0]   div_ext_c;
    logic                  ge_c;
    logic [DATA_WIDTH-1:0] rem_nxt_c;
    logic [DATA_WIDTH-1:0] quo_nxt_c;

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0]         lz_c;

    // Leading-zero count; returns DATA_WIDTH for an all-zero word.
    function automatic logic [CW-1:0] lead_zeros(input logic [DATA_WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(DATA_WIDTH);
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (v[i]) begin
                n = CW'(int'(DATA_WIDTH) - 1 - i);
            end
        end
        return n;
    endfunction

    // Capture values with the dividend normalised to its leading one.
    always_comb begin
        lz_c        = lead_zeros(in1);
        zero_iter_c = (in2 == '0) || lz_c[CW-1];
        quo_load_c  = in1 << lz_c;
        cnt_load_c  = lz_c[DATA_LOG2-1:0];
    end
`else
    // Capture values for the fixed-length iteration.
    always_comb begin
        zero_iter_c = (in2 == '0);
        quo_load_c  = in1;
        cnt_load_c  = '0;
    end
`endif

    // One restoring step; compare/subtract is one bit wider than the operands.
    always_comb begin
        rem_sh_c  = {rem, quo[DATA_WIDTH-1]};
        div_ext_c = {1'b0, divisor};
        ge_c      = (rem_sh_c >= div_ext_c);
        rem_nxt_c = ge_c ? DATA_WIDTH'(rem_sh_c - div_ext_c) : DATA_WIDTH'(rem_sh_c);
        quo_nxt_c = {quo[DATA_WIDTH-2:0], ge_c};
    end

    // State register.
    always_ff @(posedge div_clk) begin
        if (div_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (skip) begin
                    state_nxt = DONE;
                end else if (valid_in) begin
                    state_nxt = zero_iter_c ? IDLE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (valid_in) begin
                    state_nxt = zero_iter_c ? IDLE : BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        accept_c  = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        resolve_c = 1'b0;
        case (state)
            IDLE: begin
                resolve_c = skip;
                accept_c  = valid_in && !skip;
            end
            BUSY: begin
                step_c   = 1'b1;
                finish_c = (cnt == LAST);
            end
            DONE: begin
                accept_c = valid_in;
            end
            default: ;
        endcase
    end

    // Operand, iteration and result registers.
    always_ff @(posedge div_clk) begin
        if (div_rst) begin
            dividend    <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            skip        <= 1'b0;
            out_q       <= '0;
            out_r       <= '0;
            valid_out   <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid_out <= finish_c || resolve_c;
            busy      <= (state_nxt == BUSY);

            if (accept_c) begin
                dividend    <= in1;
                divisor     <= in2;
                rem         <= '0;
                quo         <= quo_load_c;
                cnt         <= cnt_load_c;
                skip        <= zero_iter_c;
                div_by_zero <= 1'b0;
            end else if (step_c) begin
                rem <= rem_nxt_c;
                quo <= quo_nxt_c;
                cnt <= cnt + DATA_LOG2'(1);
            end

            // Zero-iteration result: the remainder is the dividend in both cases.
            if (resolve_c) begin
                skip        <= 1'b0;
                out_q       <= (divisor == '0) ? '1 : '0;
                out_r       <= dividend;
                div_by_zero <= (divisor == '0);
            end

            if (finish_c) begin
                out_q       <= quo_nxt_c;
                out_r       <= rem_nxt_c;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_loproc_divider.sv
// -----------------------------------------------------------------------------
// tb_loproc_divider
// Scoreboard bench: the driver pushes the expected result and the edge at which
// it must appear; a negedge monitor pops and compares on every valid_out.
// -----------------------------------------------------------------------------
module tb_loproc_divider;

    localparam int unsigned W = 32;

    logic         div_clk = 1'b0;
    logic         div_rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         valid_in;
    logic [W-1:0] out_q;
    logic [W-1:0] out_r;
    logic         valid_out;
    logic         busy;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_vo  = 1'b0;

    loproc_divider dut (
        .div_clk     (div_clk),
        .div_rst     (div_rst),
        .in1         (in1),
        .in2         (in2),
        .valid_in    (valid_in),
        .out_q       (out_q),
        .out_r       (out_r),
        .valid_out   (valid_out),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 div_clk = ~div_clk;

    // Number of rising edges seen so far.
    always @(posedge div_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Select the hand-computed latency for the build being simulated.
    function automatic int pick(input int lat_fixed, input int lat_early);
`ifdef DIV_EARLY_TERM_EN
        return lat_early;
`else
        return lat_fixed;
`endif
    endfunction

    // Reference latency for random operands.
    function automatic int lat_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sig;
        if (b == 0) return 1;
`ifdef DIV_EARLY_TERM_EN
        if (a == 0) return 1;
        sig = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] && sig == 0) sig = i + 1;
        end
        return sig;
`else
        sig = int'(a[0]);
        return W + sig - sig;
`endif
    endfunction

    // Drive one strobe at a negedge; optionally register the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic expect_it,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                         input int lat);
        exp_t e;
        in1      = a;
        in2      = b;
        valid_in = 1'b1;
        if (expect_it) begin
            e.q   = q;
            e.r   = r;
            e.dbz = dbz;
            e.due = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge div_clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge div_clk);
            n++;
        end
        check({"drain_", name}, W'(sb.size()), '0);
        sb.delete();
        @(negedge div_clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_q"},     out_q,           '0);
        check({name, "_r"},     out_r,           '0);
        check({name, "_dbz"},   W'(div_by_zero), '0);
        check({name, "_busy"},  W'(busy),        '0);
        check({name, "_valid"}, W'(valid_out),   '0);
    endtask

    // Monitor: every valid_out must match the oldest pending expectation.
    always @(negedge div_clk) begin
        if (!div_rst && valid_out) begin
            check("valid_out_pulse", W'(prev_vo), '0);
            check("result_expected", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_q",       out_q,           mon_e.q);
                check("out_r",       out_r,           mon_e.r);
                check("div_by_zero", W'(div_by_zero), W'(mon_e.dbz));
                check("latency",     W'(cyc),         W'(mon_e.due));
            end
        end
        prev_vo = valid_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        logic [W-1:0] a;
        logic [W-1:0] b;

        div_rst  = 1'b1;
        valid_in = 1'b0;
        in1      = '0;
        in2      = '0;
        repeat (3) @(negedge div_clk);
        check_zero("reset");

        // Accepted on the first edge after reset release.
        div_rst = 1'b0;
        issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, pick(32, 7));
        wait_idle("100_7");

        issue(32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
        wait_idle("ffff_1");
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b0, 32);
        wait_idle("ffff_8000");
        issue(32'd0, 32'd9, 1'b1, 32'd0, 32'd0, 1'b0, pick(32, 1));
        wait_idle("0_9");
        issue(32'd3, 32'd2, 1'b1, 32'd1, 32'd1, 1'b0, pick(32, 2));
        wait_idle("3_2");

        // Divide by zero, then the next accepted op clears the flag.
        issue(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        wait_idle("5_0");
        check("dbz_held", W'(div_by_zero), W'(1));
        issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, pick(32, 4));
        check("dbz_cleared", W'(div_by_zero), '0);
        wait_idle("9_3");

        // Strobe while busy is ignored; strobe during DONE is accepted.
        issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, pick(32, 7));
        k = pick(10, 3);
        repeat (k) @(negedge div_clk);
        check("busy_mid", W'(busy), W'(1));
        issue(32'd50, 32'd5, 1'b0, '0, '0, 1'b0, 0);
        k = 0;
        while (!valid_out && k < 60) begin
            @(negedge div_clk);
            k++;
        end
        check("done_seen", W'(valid_out), W'(1));
        issue(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, pick(32, 6));
        check("busy_after_done", W'(busy), W'(1));
        wait_idle("50_5");

        // Reset mid-divide aborts without a result pulse.
        issue(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, pick(32, 10));
        repeat (pick(16, 5)) @(negedge div_clk);
        div_rst = 1'b1;
        sb.delete();
        @(negedge div_clk);
        check_zero("abort");
        div_rst = 1'b0;
        issue(32'd20, 32'd6, 1'b1, 32'd3, 32'd2, 1'b0, pick(32, 5));
        wait_idle("20_6");

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) b = '0;
            else                            b = $urandom() >> $urandom_range(0, 31);
            if (b == 0) issue(a, b, 1'b1, '1, a, 1'b1, lat_model(a, b));
            else        issue(a, b, 1'b1, a / b, a % b, 1'b0, lat_model(a, b));
            wait_idle("random");
        end

        repeat (4) @(negedge div_clk);
        check("final_queue", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
